// File: rtl/snake_cell_map.sv
// snake_cell_map: double-buffered cell map for the snake game display.
// The VGA side reads entity codes from the front bank through a two-stage
// pipeline, while game logic writes, clears or swaps the back bank.
// Banks only exchange roles at the frame boundary, so the field never tears.

module snake_cell_map #(
    parameter int H_SQUARE = 16,
    parameter int V_SQUARE = 16,
    parameter int H_CELLS  = 40,
    parameter int V_CELLS  = 30,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_N,
    input  logic [9:0]  iVGA_X,
    input  logic [9:0]  iVGA_Y,
    output logic [9:0]  oVGA_X,
    output logic [9:0]  oVGA_Y,
    output logic [0:1]  ent,
    input  logic        iWr_req,
    input  logic [5:0]  iWr_col,
    input  logic [4:0]  iWr_row,
    input  logic [1:0]  iWr_ent,
    output logic        oWr_ack,
    input  logic        iClr_req,
    input  logic        iSwap_req,
    output logic        oSwap_done,
    output logic        oBusy
);

    localparam int NUM_CELLS = H_CELLS * V_CELLS;
    localparam int H_SHIFT   = $clog2(H_SQUARE);
    localparam int V_SHIFT   = $clog2(V_SQUARE);
    localparam int IDX_W     = 11;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CELLS - 1);
    localparam logic [9:0]       H_ACT       = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT       = 10'(V_ACTIVE);
    localparam logic [1:0]       ENT_NOTHING = 2'd3;

    typedef enum logic [2:0] {
        INIT_CLEAR,
        IDLE,
        WR_ACK,
        CLEAR,
        SWAP_WAIT
    } stateType;

    stateType state;
    stateType nextState;

    logic             front;
    logic             nextFront;
    logic [IDX_W-1:0] clrCnt;
    logic [IDX_W-1:0] nextClrCnt;
    logic             swapNow;

    // Write port shared by the init clear, the back-bank clear and game writes
    logic             weBack;
    logic             weBoth;
    logic [IDX_W-1:0] wAddr;
    logic [1:0]       wData;

    logic [1:0] bank0 [NUM_CELLS];
    logic [1:0] bank1 [NUM_CELLS];

    // Read-side address generation from the current scan position
    logic [9:0]       colRd;
    logic [9:0]       rowRd;
    logic             inRangeRd;
    logic [IDX_W-1:0] idxRd;

    assign colRd     = iVGA_X >> H_SHIFT;
    assign rowRd     = iVGA_Y >> V_SHIFT;
    assign inRangeRd = (iVGA_X < H_ACT) && (iVGA_Y < V_ACT) &&
                       (colRd < 10'(H_CELLS)) && (rowRd < 10'(V_CELLS));
    assign idxRd     = IDX_W'(rowRd) * IDX_W'(H_CELLS) + IDX_W'(colRd);

    // Write-side address from the game-logic cell coordinates
    logic             wrInRange;
    logic [IDX_W-1:0] wrIdx;

    assign wrInRange = (iWr_col < 6'(H_CELLS)) && (iWr_row < 5'(V_CELLS));
    assign wrIdx     = IDX_W'(iWr_row) * IDX_W'(H_CELLS) + IDX_W'(iWr_col);

    logic swapBoundary;
    assign swapBoundary = (iVGA_X == 10'd0) && (iVGA_Y == V_ACT);

    // Pipeline stage registers
    logic [IDX_W-1:0] s1Idx;
    logic             s1Valid;
    logic [9:0]       s1X;
    logic [9:0]       s1Y;
    logic [1:0]       frontData;

    assign frontData = front ? bank1[s1Idx] : bank0[s1Idx];

    // Two-stage read pipeline: S1 latches index and coordinates, S2 the entity
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_N) begin
            s1Idx   <= '0;
            s1Valid <= 1'b0;
            s1X     <= '0;
            s1Y     <= '0;
            ent     <= ENT_NOTHING;
            oVGA_X  <= '0;
            oVGA_Y  <= '0;
        end else begin
            s1Idx   <= idxRd;
            s1Valid <= inRangeRd;
            s1X     <= iVGA_X;
            s1Y     <= iVGA_Y;
            ent     <= s1Valid ? frontData : ENT_NOTHING;
            oVGA_X  <= s1X;
            oVGA_Y  <= s1Y;
        end
    end

    // Next-state logic; also steers the single write port into the banks
    always_comb begin
        nextState  = state;
        nextFront  = front;
        nextClrCnt = clrCnt;
        weBack     = 1'b0;
        weBoth     = 1'b0;
        wAddr      = clrCnt;
        wData      = ENT_NOTHING;
        swapNow    = 1'b0;
        case (state)
            INIT_CLEAR: begin
                weBoth = 1'b1;
                if (clrCnt == LAST_IDX) begin
                    nextState  = IDLE;
                    nextClrCnt = '0;
                end else begin
                    nextClrCnt = clrCnt + 11'd1;
                end
            end
            IDLE: begin
                if (iClr_req) begin
                    nextState  = CLEAR;
                    nextClrCnt = '0;
                end else if (iSwap_req) begin
                    nextState = SWAP_WAIT;
                end else if (iWr_req) begin
                    weBack    = wrInRange;
                    wAddr     = wrIdx;
                    wData     = iWr_ent;
                    nextState = WR_ACK;
                end
            end
            WR_ACK: begin
                nextState = IDLE;
            end
            CLEAR: begin
                weBack = 1'b1;
                if (clrCnt == LAST_IDX) begin
                    nextState  = IDLE;
                    nextClrCnt = '0;
                end else begin
                    nextClrCnt = clrCnt + 11'd1;
                end
            end
            SWAP_WAIT: begin
                if (swapBoundary) begin
                    nextFront = ~front;
                    swapNow   = 1'b1;
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = INIT_CLEAR;
            end
        endcase
    end

    // State register plus registered status outputs
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_N) begin
            state      <= INIT_CLEAR;
            front      <= 1'b0;
            clrCnt     <= '0;
            oWr_ack    <= 1'b0;
            oSwap_done <= 1'b0;
            oBusy      <= 1'b1;
        end else begin
            state      <= nextState;
            front      <= nextFront;
            clrCnt     <= nextClrCnt;
            oWr_ack    <= (nextState == WR_ACK);
            oSwap_done <= swapNow;
            oBusy      <= (nextState == INIT_CLEAR) || (nextState == CLEAR) ||
                          (nextState == SWAP_WAIT);
        end
    end

    // Bank writes; the back bank is whichever one front does not select
    always_ff @(posedge iVGA_CLK) begin
        if (iRST_N) begin
            if (weBoth || (weBack && front)) begin
                bank0[wAddr] <= wData;
            end
            if (weBoth || (weBack && !front)) begin
                bank1[wAddr] <= wData;
            end
        end
    end

endmodule

// File: tb/tb_snake_cell_map.sv
// tb_snake_cell_map: randomized self-checking bench for snake_cell_map.
// The reference keeps a "front field" and a "back field" of 1200 cells;
// writes go to the back field, a swap exchanges the two fields.

module tb_snake_cell_map;

    logic       iVGA_CLK = 1'b0;
    logic       iRST_N;
    logic [9:0] iVGA_X;
    logic [9:0] iVGA_Y;
    logic [9:0] oVGA_X;
    logic [9:0] oVGA_Y;
    logic [0:1] ent;
    logic       iWr_req;
    logic [5:0] iWr_col;
    logic [4:0] iWr_row;
    logic [1:0] iWr_ent;
    logic       oWr_ack;
    logic       iClr_req;
    logic       iSwap_req;
    logic       oSwap_done;
    logic       oBusy;

    int checks = 0;
    int errors = 0;

    logic [1:0] frontField [1200];
    logic [1:0] backField  [1200];
    int         interest[$];

    // Free-running pixel clock
    always #5 iVGA_CLK = ~iVGA_CLK;

    snake_cell_map dut (
        .iVGA_CLK  (iVGA_CLK),
        .iRST_N    (iRST_N),
        .iVGA_X    (iVGA_X),
        .iVGA_Y    (iVGA_Y),
        .oVGA_X    (oVGA_X),
        .oVGA_Y    (oVGA_Y),
        .ent       (ent),
        .iWr_req   (iWr_req),
        .iWr_col   (iWr_col),
        .iWr_row   (iWr_row),
        .iWr_ent   (iWr_ent),
        .oWr_ack   (oWr_ack),
        .iClr_req  (iClr_req),
        .iSwap_req (iSwap_req),
        .oSwap_done(oSwap_done),
        .oBusy     (oBusy)
    );

    task automatic step();
        @(posedge iVGA_CLK);
        #1;
    endtask

    function automatic logic [1:0] modelPixel(input int x, input int y);
        if (x >= 640 || y >= 480) return 2'd3;
        return frontField[(y / 16) * 40 + (x / 16)];
    endfunction

    task automatic modelResetAll();
        for (int i = 0; i < 1200; i++) begin
            frontField[i] = 2'd3;
            backField[i]  = 2'd3;
        end
    endtask

    task automatic modelClearBack();
        for (int i = 0; i < 1200; i++) backField[i] = 2'd3;
    endtask

    task automatic modelSwap();
        logic [1:0] tmp [1200];
        tmp        = frontField;
        frontField = backField;
        backField  = tmp;
    endtask

    task automatic modelWrite(input int col, input int row, input logic [1:0] e);
        if (col < 40 && row < 30) begin
            backField[row * 40 + col] = e;
            interest.push_back(row * 40 + col);
        end
    endtask

    task automatic test_reset(input int holdCycles, input string tag);
        int busyCnt;
        iRST_N    = 1'b0;
        iVGA_X    = 10'd123;
        iVGA_Y    = 10'd45;
        iWr_req   = 1'b0;
        iClr_req  = 1'b0;
        iSwap_req = 1'b0;
        repeat (holdCycles) step();
        checks++;
        if (ent !== 2'd3) begin
            errors++;
            $display("[TB] FAIL %s reset ent: got %0d expected 3", tag, ent);
        end
        checks++;
        if (oVGA_X !== 10'd0 || oVGA_Y !== 10'd0) begin
            errors++;
            $display("[TB] FAIL %s reset coords: got (%0d,%0d) expected (0,0)", tag, oVGA_X, oVGA_Y);
        end
        checks++;
        if (oWr_ack !== 1'b0 || oSwap_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s reset pulses: got ack=%0b done=%0b expected 0/0", tag, oWr_ack, oSwap_done);
        end
        checks++;
        if (oBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s reset busy: got %0b expected 1", tag, oBusy);
        end
        iRST_N = 1'b1;
        modelResetAll();
        busyCnt = 0;
        while (oBusy === 1'b1 && busyCnt < 5000) begin
            busyCnt++;
            step();
        end
        checks++;
        if (busyCnt != 1200) begin
            errors++;
            $display("[TB] FAIL %s init busy cycles: got %0d expected 1200", tag, busyCnt);
        end
    endtask

    task automatic test_random_reads(input int n, input int focusIdx, input string tag);
        int qx[$];
        int qy[$];
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                int x, y, pick, idx, dc, dr;
                pick = $urandom_range(0, 3);
                if (pick == 0 || (focusIdx < 0 && interest.size() == 0)) begin
                    x = $urandom_range(0, 719);
                    y = $urandom_range(0, 539);
                end else if (pick == 1) begin
                    if ($urandom_range(0, 1) == 1) begin
                        x = 638 + $urandom_range(0, 4);
                        y = $urandom_range(0, 479);
                    end else begin
                        x = $urandom_range(0, 639);
                        y = 478 + $urandom_range(0, 4);
                    end
                end else begin
                    if (focusIdx >= 0 && (pick == 2 || interest.size() == 0))
                        idx = focusIdx;
                    else
                        idx = interest[$urandom_range(0, interest.size() - 1)];
                    dc = $urandom_range(0, 2) - 1;
                    dr = $urandom_range(0, 2) - 1;
                    x = ((idx % 40) + dc) * 16 + $urandom_range(0, 15);
                    y = ((idx / 40) + dr) * 16 + $urandom_range(0, 15);
                    if (x < 0) x = $urandom_range(0, 15);
                    if (y < 0) y = $urandom_range(0, 15);
                end
                iVGA_X = x[9:0];
                iVGA_Y = y[9:0];
                qx.push_back(x);
                qy.push_back(y);
            end
            step();
            if (i >= 1) begin
                int ex, ey;
                logic [1:0] expEnt;
                ex = qx.pop_front();
                ey = qy.pop_front();
                expEnt = modelPixel(ex, ey);
                checks++;
                if (ent !== expEnt) begin
                    errors++;
                    $display("[TB] FAIL %s ent at (%0d,%0d): got %0d expected %0d", tag, ex, ey, ent, expEnt);
                end
                checks++;
                if (oVGA_X !== ex[9:0] || oVGA_Y !== ey[9:0]) begin
                    errors++;
                    $display("[TB] FAIL %s delayed coords: got (%0d,%0d) expected (%0d,%0d)", tag, oVGA_X, oVGA_Y, ex, ey);
                end
            end
        end
        iVGA_X = 10'd700;
        iVGA_Y = 10'd10;
    endtask

    task automatic test_write_ack(input int col, input int row, input logic [1:0] e, input string tag);
        iWr_req = 1'b1;
        iWr_col = col[5:0];
        iWr_row = row[4:0];
        iWr_ent = e;
        step();
        iWr_req = 1'b0;
        modelWrite(col, row, e);
        checks++;
        if (oWr_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ack after accept: got %0b expected 1", tag, oWr_ack);
        end
        step();
        checks++;
        if (oWr_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s ack second cycle: got %0b expected 0", tag, oWr_ack);
        end
    endtask

    task automatic test_back_to_back();
        int cols[4];
        int rows[4];
        logic [1:0] ents[4];
        int k;
        for (int j = 0; j < 4; j++) begin
            cols[j] = $urandom_range(0, 39);
            rows[j] = $urandom_range(0, 29);
            ents[j] = 2'($urandom_range(0, 2));
        end
        k = 0;
        iWr_req = 1'b1;
        iWr_col = cols[0][5:0];
        iWr_row = rows[0][4:0];
        iWr_ent = ents[0];
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (oWr_ack !== ((i % 2) == 1)) begin
                errors++;
                $display("[TB] FAIL back_to_back ack cycle %0d: got %0b expected %0b", i, oWr_ack, (i % 2) == 1);
            end
            if (oWr_ack === 1'b1 && k < 4) begin
                modelWrite(cols[k], rows[k], ents[k]);
                k++;
                if (k < 4) begin
                    iWr_col = cols[k][5:0];
                    iWr_row = rows[k][4:0];
                    iWr_ent = ents[k];
                end else begin
                    iWr_req = 1'b0;
                end
            end
        end
        iWr_req = 1'b0;
    endtask

    task automatic test_swap(input bit reqOnBoundary, input string tag);
        int waitCycles;
        iSwap_req = 1'b1;
        if (reqOnBoundary) begin
            iVGA_X = 10'd0;
            iVGA_Y = 10'd480;
        end else begin
            iVGA_X = 10'd5;
            iVGA_Y = 10'd7;
        end
        step();
        iSwap_req = 1'b0;
        checks++;
        if (oSwap_done !== 1'b0 || oBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s after accept: got done=%0b busy=%0b expected 0/1", tag, oSwap_done, oBusy);
        end
        waitCycles = $urandom_range(2, 6);
        for (int i = 0; i < waitCycles; i++) begin
            iVGA_X = 10'($urandom_range(1, 700));
            iVGA_Y = 10'($urandom_range(0, 520));
            step();
            checks++;
            if (oSwap_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s early swap: got done=%0b expected 0", tag, oSwap_done);
            end
        end
        iVGA_X = 10'd0;
        iVGA_Y = 10'd480;
        step();
        modelSwap();
        checks++;
        if (oSwap_done !== 1'b1 || oBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s at boundary: got done=%0b busy=%0b expected 1/0", tag, oSwap_done, oBusy);
        end
        iVGA_X = 10'd20;
        iVGA_Y = 10'd20;
        step();
        checks++;
        if (oSwap_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s done width: got %0b expected 0", tag, oSwap_done);
        end
    endtask

    task automatic test_priority();
        int busyCnt;
        bit early;
        iClr_req  = 1'b1;
        iSwap_req = 1'b1;
        iWr_req   = 1'b1;
        iWr_col   = 6'd7;
        iWr_row   = 5'd7;
        iWr_ent   = 2'd1;
        iVGA_X    = 10'd3;
        iVGA_Y    = 10'd3;
        step();
        iClr_req = 1'b0;
        modelClearBack();
        busyCnt = 0;
        early   = 1'b0;
        while (oBusy === 1'b1 && busyCnt < 5000) begin
            busyCnt++;
            if (oWr_ack !== 1'b0 || oSwap_done !== 1'b0) early = 1'b1;
            step();
        end
        checks++;
        if (busyCnt != 1200) begin
            errors++;
            $display("[TB] FAIL priority clear busy cycles: got %0d expected 1200", busyCnt);
        end
        checks++;
        if (early) begin
            errors++;
            $display("[TB] FAIL priority pulse during clear: got 1 expected 0");
        end
        step();
        checks++;
        if (oBusy !== 1'b1 || oWr_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL priority swap before write: got busy=%0b ack=%0b expected 1/0", oBusy, oWr_ack);
        end
        repeat (3) begin
            step();
            checks++;
            if (oWr_ack !== 1'b0 || oSwap_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL priority waiting: got ack=%0b done=%0b expected 0/0", oWr_ack, oSwap_done);
            end
        end
        iVGA_X = 10'd0;
        iVGA_Y = 10'd480;
        step();
        iSwap_req = 1'b0;
        iVGA_X    = 10'd3;
        iVGA_Y    = 10'd3;
        modelSwap();
        checks++;
        if (oSwap_done !== 1'b1 || oWr_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL priority swap: got done=%0b ack=%0b expected 1/0", oSwap_done, oWr_ack);
        end
        step();
        iWr_req = 1'b0;
        modelWrite(7, 7, 2'd1);
        checks++;
        if (oWr_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL priority write ack: got %0b expected 1", oWr_ack);
        end
        step();
        checks++;
        if (oWr_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL priority ack width: got %0b expected 0", oWr_ack);
        end
    endtask

    task automatic test_reset_mid_clear();
        iClr_req = 1'b1;
        step();
        iClr_req = 1'b0;
        repeat (500) step();
        checks++;
        if (oBusy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_clear busy: got %0b expected 1", oBusy);
        end
        test_reset(1, "mid_clear");
    endtask

    // Test sequence
    initial begin
        iRST_N    = 1'b0;
        iVGA_X    = '0;
        iVGA_Y    = '0;
        iWr_req   = 1'b0;
        iWr_col   = '0;
        iWr_row   = '0;
        iWr_ent   = '0;
        iClr_req  = 1'b0;
        iSwap_req = 1'b0;
        modelResetAll();

        test_reset(3, "por");
        test_random_reads(40, -1, "after_init");

        test_write_ack(5, 3, 2'd2, "wr_5_3");
        test_swap(1'b0, "swap1");
        test_random_reads(80, 3 * 40 + 5, "after_swap1");

        test_write_ack(0, 0, 2'd0, "wr_0_0");
        test_random_reads(60, 0, "isolation");

        test_write_ack(40, 0, 2'd1, "wr_col40");
        test_write_ack(0, 30, 2'd1, "wr_row30");
        test_write_ack(0, 1, 2'd1, "wr_0_1");
        test_swap(1'b1, "swap_req_on_boundary");
        test_random_reads(80, 40, "bounds");

        test_back_to_back();
        test_swap(1'b0, "swap_b2b");
        test_random_reads(80, -1, "after_b2b");

        test_priority();
        test_random_reads(60, 3 * 40 + 5, "after_priority");
        test_swap(1'b0, "swap_after_priority");
        test_random_reads(60, 7 * 40 + 7, "priority_write");

        test_reset_mid_clear();
        test_random_reads(60, 7 * 40 + 7, "after_mid_reset");
        test_write_ack(2, 2, 2'd2, "wr_2_2");
        test_swap(1'b0, "swap_after_reset");
        test_random_reads(60, 2 * 40 + 2, "final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
